// File: rtl/rc4_sbox_ksa_fsm_if.sv
// rc4_sbox_ksa_fsm_if: control and S-memory bus between the RC4 controller, the S-box engine and the RAM.
interface rc4_sbox_ksa_fsm_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_WORDS = 3
);
  logic start;
  logic fill_only;
  logic [KEY_WORDS*DATA_W-1:0] secret_key;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic wren;
  logic busy;
  logic done;
  modport master (
    output start, fill_only, secret_key, q,
    input address, data, wren, busy, done
  );
  modport slave (
    input start, fill_only, secret_key, q,
    output address, data, wren, busy, done
  );
endinterface

// File: rtl/rc4_sbox_ksa_fsm.sv
// rc4_sbox_ksa_fsm: fills the S-memory with the identity permutation, then runs the RC4 key schedule.
module rc4_sbox_ksa_fsm #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_WORDS = 3
) (
  input logic clk,
  input logic reset,
  rc4_sbox_ksa_fsm_if.slave bus
);
  localparam int K_W = KEY_WORDS > 1 ? $clog2(KEY_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_WORDS - 1);
  typedef enum logic [3:0] {IDLE, FILL, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] i, j, j_next;
  logic [K_W-1:0] k;
  logic [KEY_WORDS*DATA_W-1:0] key;
  logic stop_after_fill;
  logic [DATA_W-1:0] si;
  logic [DATA_W-1:0] key_word [KEY_WORDS];
  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign key_word[g] = key[(KEY_WORDS-1-g)*DATA_W +: DATA_W];
  end
  assign j_next = j + bus.q[ADDR_W-1:0] + key_word[k][ADDR_W-1:0];
  // Outputs are registered for the state being entered, so the RAM sees them one cycle per state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      key <= '0;
      stop_after_fill <= 1'b0;
      si <= '0;
      bus.address <= '0;
      bus.data <= '0;
      bus.wren <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          key <= bus.secret_key;
          stop_after_fill <= bus.fill_only;
          i <= '0;
          j <= '0;
          k <= '0;
          bus.address <= '0;
          bus.data <= '0;
          bus.wren <= 1'b1;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          state <= FILL;
        end
        FILL: if (i == LAST) begin
          i <= '0;
          bus.address <= '0;
          bus.wren <= 1'b0;
          bus.busy <= !stop_after_fill;
          bus.done <= stop_after_fill;
          state <= stop_after_fill ? DONE : RD_I;
        end else begin
          i <= i + 1'b1;
          bus.address <= i + 1'b1;
          bus.data <= DATA_W'(i + 1'b1);
        end
        RD_I: state <= LAT_I;
        LAT_I: begin
          si <= bus.q;
          j <= j_next;
          bus.address <= j_next;
          state <= RD_J;
        end
        RD_J: state <= LAT_J;
        LAT_J: begin
          bus.address <= i;
          bus.data <= bus.q;
          bus.wren <= 1'b1;
          state <= WR_I;
        end
        WR_I: begin
          bus.address <= j;
          bus.data <= si;
          state <= WR_J;
        end
        WR_J: begin
          bus.wren <= 1'b0;
          k <= k == K_LAST ? '0 : k + 1'b1;
          if (i == LAST) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            i <= i + 1'b1;
            bus.address <= i + 1'b1;
            state <= RD_I;
          end
        end
        default: begin
          bus.wren <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_sbox_ksa_fsm.sv
// tb_rc4_sbox_ksa_fsm: directed bench with synchronous RAM models for a default and a 4-entry instance.
module tb_rc4_sbox_ksa_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rc4_sbox_ksa_fsm_if #(.ADDR_W(8), .DATA_W(8), .KEY_WORDS(3)) big ();
  rc4_sbox_ksa_fsm_if #(.ADDR_W(2), .DATA_W(2), .KEY_WORDS(1)) sm ();
  rc4_sbox_ksa_fsm #(.ADDR_W(8), .DATA_W(8), .KEY_WORDS(3)) dut_big (.clk(clk), .reset(reset), .bus(big.slave));
  rc4_sbox_ksa_fsm #(.ADDR_W(2), .DATA_W(2), .KEY_WORDS(1)) dut_sm (.clk(clk), .reset(reset), .bus(sm.slave));
  logic [7:0] mem_big [256];
  logic [1:0] mem_sm [4];
  always @(posedge clk) begin
    if (big.wren) mem_big[big.address] <= big.data;
    big.q <= mem_big[big.address];
  end
  always @(posedge clk) begin
    if (sm.wren) mem_sm[sm.address] <= sm.data;
    sm.q <= mem_sm[sm.address];
  end
  function automatic logic [7:0] sm_image();
    return {mem_sm[3], mem_sm[2], mem_sm[1], mem_sm[0]};
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({big.address, big.data, big.wren, big.busy, big.done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_big: addr=%0d data=%0d wren=%b busy=%b done=%b expected all zero", big.address, big.data, big.wren, big.busy, big.done);
    end
    checks++;
    if ({sm.address, sm.data, sm.wren, sm.busy, sm.done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_small: addr=%0d data=%0d wren=%b busy=%b done=%b expected all zero", sm.address, sm.data, sm.wren, sm.busy, sm.done);
    end
    reset = 1'b0;
  endtask
  task automatic test_fill_only;
    @(negedge clk);
    big.fill_only = 1'b1;
    big.secret_key = 24'hAABBCC;
    big.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    big.start = 1'b0;
    for (int n = 0; n < 256; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if ({big.wren, big.busy, big.done, big.address, big.data} !== {3'b110, 8'(n), 8'(n)}) begin
        errors++;
        $display("FAIL fill_cycle%0d: wren/busy/done=%b%b%b addr=%0d data=%0d expected 110 addr=%0d data=%0d", n, big.wren, big.busy, big.done, big.address, big.data, n, n);
      end
    end
    @(negedge clk);
    checks++;
    if ({big.wren, big.busy, big.done} !== 3'b001) begin
      errors++;
      $display("FAIL fill_done_256: wren/busy/done=%b%b%b expected 001", big.wren, big.busy, big.done);
    end
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (mem_big[a] !== 8'(a)) begin
        errors++;
        $display("FAIL fill_mem[%0d]: got %0d expected %0d", a, mem_big[a], a);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({big.wren, big.busy, big.done} !== 3'b001) begin
      errors++;
      $display("FAIL fill_done_sticky: wren/busy/done=%b%b%b expected 001", big.wren, big.busy, big.done);
    end
  endtask
  task automatic test_ksa_small(input logic [1:0] key, input logic [1:0] exp_j0, input logic [7:0] exp_swap0, input logic [7:0] exp_final);
    int writes = 0;
    bit early_done = 1'b0;
    @(negedge clk);
    sm.fill_only = 1'b0;
    sm.secret_key = key;
    sm.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sm.start = 1'b0;
    for (int n = 0; n < 28; n++) begin
      if (n > 0) @(negedge clk);
      if (sm.wren) writes++;
      if (sm.done) early_done = 1'b1;
      if (n == 6) begin
        checks++;
        if (sm.address !== exp_j0) begin
          errors++;
          $display("FAIL ksa_key%0d_j0: addr=%0d expected %0d", key, sm.address, exp_j0);
        end
      end
      if (n == 10) begin
        checks++;
        if (sm_image() !== exp_swap0) begin
          errors++;
          $display("FAIL ksa_key%0d_swap0: mem=%h expected %h", key, sm_image(), exp_swap0);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({early_done, sm.busy, sm.done} !== 3'b001) begin
      errors++;
      $display("FAIL ksa_key%0d_done28: early/busy/done=%b%b%b expected 001", key, early_done, sm.busy, sm.done);
    end
    checks++;
    if (writes !== 12) begin
      errors++;
      $display("FAIL ksa_key%0d_writes: got %0d expected 12", key, writes);
    end
    checks++;
    if (sm_image() !== exp_final) begin
      errors++;
      $display("FAIL ksa_key%0d_final: mem=%h expected %h", key, sm_image(), exp_final);
    end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    sm.fill_only = 1'b0;
    sm.secret_key = 2'd2;
    sm.start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 58; n++) begin
      @(negedge clk);
      if (n == 10) begin
        sm.secret_key = 2'd0;
        sm.fill_only = 1'b1;
      end
      if (n == 38) sm.start = 1'b0;
      if (n == 27 || n == 56) begin
        checks++;
        if ({sm.busy, sm.done} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_busy%0d: busy/done=%b%b expected 10", n, sm.busy, sm.done);
        end
      end
      if (n == 28) begin
        checks++;
        if ({sm.busy, sm.done, sm_image()} !== {2'b01, 8'h72}) begin
          errors++;
          $display("FAIL b2b_first: busy/done=%b%b mem=%h expected 01 72", sm.busy, sm.done, sm_image());
        end
        sm.fill_only = 1'b0;
      end
      if (n == 29) begin
        checks++;
        if ({sm.wren, sm.busy, sm.done, sm.address} !== {3'b110, 2'd0}) begin
          errors++;
          $display("FAIL b2b_rerun: wren/busy/done=%b%b%b addr=%0d expected 110 addr=0", sm.wren, sm.busy, sm.done, sm.address);
        end
      end
      if (n == 57 || n == 58) begin
        checks++;
        if ({sm.busy, sm.done, sm_image()} !== {2'b01, 8'h78}) begin
          errors++;
          $display("FAIL b2b_second%0d: busy/done=%b%b mem=%h expected 01 78", n, sm.busy, sm.done, sm_image());
        end
      end
    end
  endtask
  task automatic test_reset_midrun;
    @(negedge clk);
    big.fill_only = 1'b0;
    big.secret_key = 24'h010203;
    big.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    big.start = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if ({big.wren, big.busy} !== 2'b11) begin
      errors++;
      $display("FAIL midrun_pre: wren/busy=%b%b expected 11", big.wren, big.busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({big.wren, big.busy, big.done} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_async_reset: wren/busy/done=%b%b%b expected 000", big.wren, big.busy, big.done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_full_ksa;
    logic [7:0] s [256];
    logic [7:0] kw [3];
    logic [7:0] t;
    int jj = 0;
    int writes = 0;
    int seen [256];
    int dup = 0;
    bit early_done = 1'b0;
    kw[0] = 8'h01;
    kw[1] = 8'h02;
    kw[2] = 8'h03;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(s[a]) + int'(kw[a % 3])) % 256;
      t = s[a];
      s[a] = s[jj];
      s[jj] = t;
    end
    @(negedge clk);
    big.fill_only = 1'b0;
    big.secret_key = 24'h010203;
    big.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    big.start = 1'b0;
    big.secret_key = 24'hFFFFFF;
    for (int n = 0; n < 1792; n++) begin
      if (n > 0) @(negedge clk);
      if (big.wren) writes++;
      if (big.done) early_done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({early_done, big.busy, big.done} !== 3'b001) begin
      errors++;
      $display("FAIL full_done1792: early/busy/done=%b%b%b expected 001", early_done, big.busy, big.done);
    end
    checks++;
    if (writes !== 768) begin
      errors++;
      $display("FAIL full_writes: got %0d expected 768", writes);
    end
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (mem_big[a] !== s[a]) begin
        errors++;
        $display("FAIL full_mem[%0d]: got %0d expected %0d", a, mem_big[a], s[a]);
      end
      seen[a] = 0;
    end
    for (int a = 0; a < 256; a++) seen[mem_big[a]]++;
    for (int a = 0; a < 256; a++) if (seen[a] != 1) dup++;
    checks++;
    if (dup !== 0) begin
      errors++;
      $display("FAIL full_permutation: %0d values not present exactly once, expected 0", dup);
    end
  endtask
  initial begin
    big.start = 1'b0;
    big.fill_only = 1'b0;
    big.secret_key = '0;
    sm.start = 1'b0;
    sm.fill_only = 1'b0;
    sm.secret_key = '0;
    test_reset();
    test_fill_only();
    test_ksa_small(2'd0, 2'd0, 8'hE4, 8'h78);
    test_ksa_small(2'd1, 2'd1, 8'hE1, 8'h78);
    test_back_to_back();
    test_reset_midrun();
    test_full_ksa();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
